// File: rtl/button_pkg.sv
// Shared constants for the push-button front-end and reaction_game timing:
// debounce FSM state encoding, system clock rate and a ms-to-cycles helper.
package button_pkg;

   typedef enum logic [1:0] {
      UP        = 2'd0,
      PEND_DOWN = 2'd1,
      DOWN      = 2'd2,
      PEND_UP   = 2'd3
   } state_t;

   localparam int unsigned CLK_HZ = 12000000;

   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on
// asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Push-button synchroniser, debouncer and press/release strobe generator.
// Optional hold detection is built when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10),
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned LONG_CYCLES     = ms_to_cycles(1000)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             pin_pressed, level_sync;
   logic             press_d, release_d;

   // Polarity is normalised before synchronising so reset 0 means "not pressed".
   assign pin_pressed = button ^ ACTIVE_LOW;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pin_pressed),
      .q     (level_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= UP;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= next_state;
         cnt           <= cnt_next;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         UP: begin
            if (level_sync) begin
               next_state = PEND_DOWN;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         PEND_DOWN: begin
            if (!level_sync) begin
               next_state = UP;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               next_state = DOWN;
               cnt_next   = '0;
            end else if (cnt != CNT_MAX) begin
               cnt_next   = cnt + CNT_ONE;
            end
         end
         DOWN: begin
            if (!level_sync) begin
               next_state = PEND_UP;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         PEND_UP: begin
            if (level_sync) begin
               next_state = DOWN;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               next_state = UP;
               cnt_next   = '0;
            end else if (cnt != CNT_MAX) begin
               cnt_next   = cnt + CNT_ONE;
            end
         end
         default: begin
            next_state = UP;
            cnt_next   = '0;
         end
      endcase
   end

   // Strobes fire on the accepting transition and are registered above.
   always_comb begin
      btn_level = (state == DOWN) || (state == PEND_UP);
      press_d   = (state == PEND_DOWN) && (next_state == DOWN);
      release_d = (state == PEND_UP) && (next_state == UP);
   end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_cnt;

   // A bounce back from PEND_UP keeps counting; only a fresh press restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         if (press_d)
            hold_cnt <= '0;
         else if (btn_level && (hold_cnt != HOLD_MAX))
            hold_cnt <= hold_cnt + HOLD_ONE;

         if (next_state == UP)
            long_press <= 1'b0;
         else if (btn_level && (hold_cnt >= HOLD_MAX - HOLD_ONE))
            long_press <= 1'b1;
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front-end for reaction_game. It takes the raw mechanical push-button pin and makes it safe to use.
- It synchronises the pin to clk, debounces it, and produces a clean level plus single-cycle press and release strobes.
- reaction_game consumes press_pulse in place of sampling the raw button. This removes metastability and multiple bounce-induced triggers, which would corrupt reaction-time measurement.
- Target clock is 12 MHz.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronised samples required to accept a new level (10 ms at 12 MHz); legal range 2..2^24-1.
- ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; the block inverts internally so all outputs are active-high "pressed".
- LONG_CYCLES, 12000000, held-pressed cycles before long_press asserts (1 s at 12 MHz); used only with the optional feature.

Ports:
- clk  input  1  system clock, 12 MHz, all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- button  input  1  raw asynchronous push-button pin
- btn_level  output  1  debounced pressed level, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_press  output  1  level, high while held beyond LONG_CYCLES (only with LONG_PRESS_EN; otherwise tied 0)

Behaviour:
- Reset: asynchronous, active-low on rst_n, as already decided.
  - On rst_n low, immediately: sync_ff1 and sync_ff2 = 0 (not-pressed after polarity fix), state = UP, cnt = 0, all outputs = 0.
  - Release of reset is used synchronously; no output changes in the first cycle after deassertion.
- Synchroniser:
  - s = button XOR ACTIVE_LOW.
  - Two-flop chain sync_ff1 <= s, sync_ff2 <= sync_ff1.
  - Only sync_ff2 is used downstream.
- Counter: cnt width = $clog2(DEBOUNCE_CYCLES+1), and it saturates, never wraps.
- FSM states:
  - UP: btn_level=0. If sync_ff2=1, go to PEND_DOWN with cnt <= 1; else cnt <= 0.
  - PEND_DOWN:
    - If sync_ff2=0, return to UP with cnt <= 0 (bounce rejected, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to DOWN; btn_level <= 1 and press_pulse <= 1 for exactly one cycle.
    - Else cnt <= cnt+1.
  - DOWN: btn_level=1. If sync_ff2=0, go to PEND_UP with cnt <= 1.
  - PEND_UP:
    - If sync_ff2=1, return to DOWN, no pulse.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to UP; btn_level <= 0 and release_pulse <= 1 for one cycle.
    - Else cnt <= cnt+1.
- Latency: a clean step on button produces press_pulse high exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples the new pin value.
- Outputs: all registered; no combinational path from button to any output.
- Simultaneous events:
  - press_pulse and release_pulse are never high in the same cycle.
  - The minimum spacing between them is DEBOUNCE_CYCLES cycles.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES stable samples never produces a pulse or a btn_level change.
- Reset mid-PEND or mid-DOWN:
  - All state clears immediately.
  - No release_pulse is generated for the aborted press.
  - A button still held after reset is re-accepted as a fresh press after the full latency.

Optional Feature:
- Macro: BUTTON_CONDITIONER_LONG_PRESS_EN.
- When defined:
  - A hold counter of width $clog2(LONG_CYCLES+1) clears on entry to DOWN and increments each cycle in DOWN or PEND_UP.
  - It saturates at LONG_CYCLES.
  - long_press <= 1 when the counter reaches LONG_CYCLES.
  - long_press <= 0 on entry to UP, and on reset.
  - A bounce that returns PEND_UP to DOWN does not clear the hold counter.
- When not defined: the hold counter is absent; long_press is constant 0.
- The port exists in both builds.

Decomposition:
- Package button_pkg holds:
  - the state enum/localparams UP=2'd0, PEND_DOWN=2'd1, DOWN=2'd2, PEND_UP=2'd3;
  - CLK_HZ=12000000;
  - the ms-to-cycles constant function shared with reaction_game timing.
- One natural sub-module: sync_2ff (parameterless two-flop synchroniser with async active-low reset to 0). It is reused for any other asynchronous input later.

Test Plan (bench overrides DEBOUNCE_CYCLES=8, LONG_CYCLES=40):
- Reset hold: rst_n=0 with button toggling -> all outputs 0; after deassert with button=0, outputs stay 0.
- Clean press: button 0->1 held 20 cycles -> press_pulse high exactly one cycle, 10 edges after step; btn_level=1 from that cycle onward.
- Bounce rejection:
  - button pattern 1,0,1,1,0,1 (one cycle each) then 0 -> no press_pulse, btn_level stays 0.
  - Same bounce then hold 1 -> single press_pulse 10 cycles after the last 0->1.
- Clean release: from pressed, button 1->0 held 20 cycles -> one release_pulse 10 edges later; btn_level=0.
- ACTIVE_LOW=1 instance: pin driven 1->0 -> press_pulse after 10 cycles; pin 0->1 -> release_pulse.
- Reset mid-press and long press:
  - rst_n pulsed low during DOWN -> outputs 0 at once, no release_pulse; button still high -> new press_pulse 10 cycles after deassert.
  - With LONG_PRESS_EN: held 60 cycles -> long_press rises 40 cycles after press_pulse and falls with release_pulse.
